// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM encoding and buffer entry layout for the instruction fetch unit.
package fetch_unit_pkg;
    localparam int WIDTH_WORD   = 8;
    localparam int WIDTH_DOUBLE = 16;
    localparam int WIDTH_ENTRY  = 2 * WIDTH_DOUBLE;

    typedef enum logic [1:0] {
        RDLO = 2'd0,
        RDHI = 2'd1,
        PUSH = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// In-order op buffer; entries are {op_pc, op}. Flush empties it in one cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          push,
    input  logic [WIDTH_ENTRY-1:0]        wdata,
    input  logic                          pop,
    output logic [WIDTH_ENTRY-1:0]        rdata,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH_ENTRY-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is cleared on reset so op/op_pc read as zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Byte-wide instruction fetcher: two reads per 16-bit op, buffered ahead of the consumer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect,
    input  logic [WIDTH_DOUBLE-1:0] redirect_pc,
    input  logic                    halt,
    output logic                    mem_rd,
    output logic [WIDTH_DOUBLE-1:0] mem_addr,
    input  logic [WIDTH_WORD-1:0]   mem_rdata,
    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [WIDTH_DOUBLE-1:0] op,
    output logic [WIDTH_DOUBLE-1:0] op_pc
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t            state, state_nxt;
    logic [WIDTH_DOUBLE-1:0] fpc;
    logic [WIDTH_WORD-1:0]   lo;
    logic [CW-1:0]           count;
    logic [CW:0]             occ_nxt;
    logic [WIDTH_ENTRY-1:0]  head;
    logic                    pop, push, start, rd;
    logic [WIDTH_DOUBLE-1:0] addr;

    assign op_valid = (count != '0);
    assign pop      = op_valid & op_ready & ~redirect;
    assign push     = (state == PUSH) & ~redirect;
    assign occ_nxt  = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(push);
    // A low-byte read is only launched if the op it produces is guaranteed a slot.
    assign start    = ~halt & ~redirect & (state != RDHI) & (occ_nxt < (CW+1)'(DEPTH));

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        addr      = fpc;
        case (state)
            RDLO: begin
                rd = start;
                if (start) state_nxt = RDHI;
            end
            RDHI: begin
                rd        = 1'b1;
                addr      = fpc + 16'd1;
                state_nxt = PUSH;
            end
            PUSH: begin
                // Overlap the next op's low-byte read with this push.
                rd        = start;
                addr      = fpc + 16'd2;
                state_nxt = start ? RDHI : RDLO;
            end
            default: state_nxt = RDLO;
        endcase
        if (redirect) begin
            rd        = 1'b0;
            state_nxt = RDLO;
        end
    end

    assign mem_rd   = rd & rst_n;
    assign mem_addr = mem_rd ? addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RDLO;
            fpc   <= RESET_PC;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            if (redirect)           fpc <= redirect_pc;
            else if (state == PUSH) fpc <= fpc + 16'd2;
            if (state == RDHI)      lo  <= mem_rdata;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .wdata ({fpc, mem_rdata, lo}),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    assign op    = head[WIDTH_DOUBLE-1:0];
    assign op_pc = head[WIDTH_ENTRY-1:WIDTH_DOUBLE];
endmodule
